rv32_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences the single shared 32-bit adder ALU (operands reg_a / reg_rdx, output result) between PC increment, address generation, link computation and execute.
- Drives operand-select muxes, register and PC write enables, and the instruction/data memory request handshakes.
- Supported subset (all adder-only): ADD, ADDI, LW, SW, LUI, AUIPC, JAL, JALR. Everything else is flagged illegal and skipped.

---
 rtl/rv32_multicycle_ctrl_pkg.sv | 58 +++++
 rtl/rv32_multicycle_ctrl_if.sv | 24 ++
 rtl/rv32_ctrl_decode.sv | 38 +++
 rtl/rv32_multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_multicycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control FSM.
package rv32_multicycle_ctrl_pkg;

  // FSM state encoding, kept as plain constants so older tools can consume it.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_LINK   = 3'd5;
  localparam logic [2:0] ST_PC_INC = 3'd6;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } alu_a_sel_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } alu_b_sel_e;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_ALUOUT = 2'd1,
    WB_LOAD   = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_ALU          = 2'd0,
    PC_ALUOUT       = 2'd1,
    PC_ALUOUT_ALIGN = 2'd2
  } pc_src_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_OP      = 4'd1,
    CLS_OP_IMM  = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8
  } instr_class_e;

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Instruction and data memory request/ready handshakes of the control FSM.
interface rv32_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/rv32_ctrl_decode.sv
// Combinational instruction classifier for the adder-only RV32I subset.
module rv32_ctrl_decode
  import rv32_multicycle_ctrl_pkg::*;
(
  input  logic [31:0]  ir_i,
  output instr_class_e class_o,
  output logic         rd_is_zero_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs_fields;

  assign opcode           = ir_i[6:0];
  assign funct3           = ir_i[14:12];
  assign funct7           = ir_i[31:25];
  assign rd_is_zero_o     = (ir_i[11:7] == 5'd0);
  // Register specifiers only steer the datapath, never the sequencing.
  assign unused_rs_fields = ^ir_i[24:15];

  // Anything outside the supported encodings falls through to illegal.
  always_comb begin
    class_o = CLS_ILLEGAL;
    case (opcode)
      OPC_OP:     if (funct3 == 3'b000 && funct7 == 7'b0000000) class_o = CLS_OP;
      OPC_OP_IMM: if (funct3 == 3'b000) class_o = CLS_OP_IMM;
      OPC_LOAD:   if (funct3 == 3'b010) class_o = CLS_LOAD;
      OPC_STORE:  if (funct3 == 3'b010) class_o = CLS_STORE;
      OPC_LUI:    class_o = CLS_LUI;
      OPC_AUIPC:  class_o = CLS_AUIPC;
      OPC_JAL:    class_o = CLS_JAL;
      OPC_JALR:   if (funct3 == 3'b000) class_o = CLS_JALR;
      default:    class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle control FSM sequencing the shared adder ALU of the RV32I core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | imem request held until ready; ready latches IR
// DECODE  | classify IR, flag illegal encodings
// EXEC    | adder computes result/address/target into ALUOUT
// MEM     | data access at ALUOUT, store or load
// WB      | write ALUOUT or load data to rd
// LINK    | rd <= PC+4, PC <= latched jump target
// PC_INC  | PC <= PC+4, instruction retires
module rv32_multicycle_ctrl
  import rv32_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32_multicycle_ctrl_if.master bus,
  input  logic [31:0]           ir_i,
  output logic                  ir_we_o,
  output logic [1:0]            alu_a_sel_o,
  output logic [1:0]            alu_b_sel_o,
  output logic                  alu_out_we_o,
  output logic                  rf_we_o,
  output logic [1:0]            wb_sel_o,
  output logic                  pc_we_o,
  output logic [1:0]            pc_src_o,
  output logic                  illegal_instr_o,
  output logic                  bus_error_o,
  output logic [CNT_W-1:0]      instret_o
);

  localparam int unsigned     TO_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

  logic [2:0]       state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] instret_q;

  instr_class_e instr_class;
  logic         rd_is_zero;
  logic         timeout_hit;

  logic       imem_req, dmem_req, dmem_we, ir_we, alu_out_we, rf_we, pc_we;
  logic       illegal_instr, bus_error;
  alu_a_sel_e a_sel;
  alu_b_sel_e b_sel;
  wb_sel_e    wb_sel;
  pc_src_e    pc_src;

  rv32_ctrl_decode u_decode (
    .ir_i         (ir_i),
    .class_o      (instr_class),
    .rd_is_zero_o (rd_is_zero)
  );

  assign timeout_hit = TO_EN && (timer_q == TO_LIMIT);

  // Next state and per-state control decode; ready wins over a same-cycle timeout.
  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    alu_out_we    = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    a_sel         = A_RS1;
    b_sel         = B_RS2;
    wb_sel        = WB_ALU;
    pc_src        = PC_ALU;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          bus_error = 1'b1;
          state_d   = ST_PC_INC;
        end
      end
      ST_DECODE: begin
        if (instr_class == CLS_ILLEGAL) begin
          illegal_instr = 1'b1;
          state_d       = ST_PC_INC;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_out_we = 1'b1;
        b_sel      = B_IMM;
        state_d    = ST_WB;
        case (instr_class)
          CLS_OP:    b_sel = B_RS2;
          CLS_LUI:   a_sel = A_ZERO;
          CLS_AUIPC: a_sel = A_PC;
          CLS_LOAD,
          CLS_STORE: state_d = ST_MEM;
          CLS_JAL: begin
            a_sel   = A_PC;
            state_d = ST_LINK;
          end
          CLS_JALR:  state_d = ST_LINK;
          default:   a_sel = A_RS1;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (instr_class == CLS_STORE);
        if (bus.dmem_ready) begin
          state_d = (instr_class == CLS_STORE) ? ST_PC_INC : ST_WB;
        end else if (timeout_hit) begin
          bus_error = 1'b1;
          state_d   = ST_PC_INC;
        end
      end
      ST_WB: begin
        rf_we   = ~rd_is_zero;
        wb_sel  = (instr_class == CLS_LOAD) ? WB_LOAD : WB_ALUOUT;
        state_d = ST_PC_INC;
      end
      ST_LINK: begin
        // Target already sits in ALUOUT, so rd == rs1 cannot corrupt it.
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        rf_we   = ~rd_is_zero;
        wb_sel  = WB_ALU;
        pc_we   = 1'b1;
        pc_src  = (instr_class == CLS_JAL) ? PC_ALUOUT : PC_ALUOUT_ALIGN;
        state_d = ST_FETCH;
      end
      ST_PC_INC: begin
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        pc_we   = 1'b1;
        pc_src  = PC_ALU;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Wait counter restarts whenever a new state is entered and saturates at the limit.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TO_LIMIT) begin
      timer_d = timer_q + TO_W'(1);
    end
  end

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      timer_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Outputs are held low while reset is applied, even before state is known.
  assign bus.imem_req    = ~rst & imem_req;
  assign bus.dmem_req    = ~rst & dmem_req;
  assign bus.dmem_we     = ~rst & dmem_we;
  assign ir_we_o         = ~rst & ir_we;
  assign alu_out_we_o    = ~rst & alu_out_we;
  assign rf_we_o         = ~rst & rf_we;
  assign pc_we_o         = ~rst & pc_we;
  assign illegal_instr_o = ~rst & illegal_instr;
  assign bus_error_o     = ~rst & bus_error;
  assign alu_a_sel_o     = rst ? 2'b00 : a_sel;
  assign alu_b_sel_o     = rst ? 2'b00 : b_sel;
  assign wb_sel_o        = rst ? 2'b00 : wb_sel;
  assign pc_src_o        = rst ? 2'b00 : pc_src;
  assign instret_o       = rst ? '0 : instret_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Randomized bench for rv32_multicycle_ctrl against a per-instruction cycle model.
module tb_rv32_multicycle_ctrl;

  localparam int LIMIT = 4;
  localparam int CW    = 4;
  localparam int C_ILL = 0, C_OP = 1, C_OPI = 2, C_LD = 3, C_ST = 4;
  localparam int C_LUI = 5, C_AUI = 6, C_JAL = 7, C_JALR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ir;
  logic          ir_we, alu_out_we, rf_we, pc_we, illegal, bus_err;
  logic [1:0]    a_sel, b_sel, wb_sel, pc_src;
  logic [CW-1:0] instret;

  rv32_multicycle_ctrl_if bus_if ();

  rv32_multicycle_ctrl #(.TIMEOUT_CYCLES(LIMIT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if),
    .ir_i            (ir),
    .ir_we_o         (ir_we),
    .alu_a_sel_o     (a_sel),
    .alu_b_sel_o     (b_sel),
    .alu_out_we_o    (alu_out_we),
    .rf_we_o         (rf_we),
    .wb_sel_o        (wb_sel),
    .pc_we_o         (pc_we),
    .pc_src_o        (pc_src),
    .illegal_instr_o (illegal),
    .bus_error_o     (bus_err),
    .instret_o       (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_we, alu_out_we, rf_we, pc_we;
    logic        illegal, bus_err;
    logic        chk_alu, chk_wb, chk_pc;
    logic [1:0]  a_sel, b_sel, wb_sel, pc_src;
  } cyc_t;

  cyc_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_ret = 0;
  logic [31:0] cur_ir = 32'h0;
  bit          junk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural class of a word, straight from the supported-subset rules.
  function automatic int classify(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'b0110011: return (f3 == 3'b000 && w[31:25] == 7'b0) ? C_OP : C_ILL;
      7'b0010011: return (f3 == 3'b000) ? C_OPI : C_ILL;
      7'b0000011: return (f3 == 3'b010) ? C_LD : C_ILL;
      7'b0100011: return (f3 == 3'b010) ? C_ST : C_ILL;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUI;
      7'b1101111: return C_JAL;
      7'b1100111: return (f3 == 3'b000) ? C_JALR : C_ILL;
      default:    return C_ILL;
    endcase
  endfunction

  // Idle cycle: no strobes; readies carry noise when junk is on.
  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.ir         = cur_ir;
    c.imem_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    c.dmem_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    return c;
  endfunction

  task automatic push_pcinc();
    cyc_t c;
    c = blank();
    c.chk_alu = 1'b1; c.a_sel = 2'd1; c.b_sel = 2'd2;
    c.pc_we = 1'b1; c.chk_pc = 1'b1; c.pc_src = 2'd0;
    exp_q.push_back(c);
  endtask

  // Expected cycle trace of one instruction given fetch and data ready delays.
  task automatic model_instr(input logic [31:0] w, input int di, input int dd);
    cyc_t c;
    int   cls;
    logic rd0;
    bit   done;
    cls  = classify(w);
    rd0  = (w[11:7] == 5'd0);
    done = 1'b0;
    for (int k = 0; k <= LIMIT && !done; k++) begin
      c = blank();
      c.imem_req = 1'b1;
      if (k == di) begin
        c.imem_ready = 1'b1; c.ir_we = 1'b1; done = 1'b1;
        exp_q.push_back(c);
      end else begin
        c.imem_ready = 1'b0;
        if (k == LIMIT) begin
          c.bus_err = 1'b1;
          exp_q.push_back(c);
          push_pcinc();
          return;
        end
        exp_q.push_back(c);
      end
    end
    cur_ir = w;
    c = blank();
    c.illegal = (cls == C_ILL);
    exp_q.push_back(c);
    if (cls == C_ILL) begin
      push_pcinc();
      return;
    end
    c = blank();
    c.alu_out_we = 1'b1; c.chk_alu = 1'b1; c.b_sel = 2'd1;
    case (cls)
      C_OP:   begin c.a_sel = 2'd0; c.b_sel = 2'd0; end
      C_LUI:  c.a_sel = 2'd2;
      C_AUI:  c.a_sel = 2'd1;
      C_JAL:  c.a_sel = 2'd1;
      default: c.a_sel = 2'd0;
    endcase
    exp_q.push_back(c);
    if (cls == C_JAL || cls == C_JALR) begin
      c = blank();
      c.chk_alu = 1'b1; c.a_sel = 2'd1; c.b_sel = 2'd2;
      c.rf_we = !rd0; c.chk_wb = 1'b1; c.wb_sel = 2'd0;
      c.pc_we = 1'b1; c.chk_pc = 1'b1; c.pc_src = (cls == C_JAL) ? 2'd1 : 2'd2;
      exp_q.push_back(c);
      return;
    end
    if (cls == C_LD || cls == C_ST) begin
      done = 1'b0;
      for (int k = 0; k <= LIMIT && !done; k++) begin
        c = blank();
        c.dmem_req = 1'b1;
        c.dmem_we  = (cls == C_ST);
        if (k == dd) begin
          c.dmem_ready = 1'b1; done = 1'b1;
          exp_q.push_back(c);
        end else begin
          c.dmem_ready = 1'b0;
          if (k == LIMIT) begin
            c.bus_err = 1'b1;
            exp_q.push_back(c);
            push_pcinc();
            return;
          end
          exp_q.push_back(c);
        end
      end
      if (cls == C_ST) begin
        push_pcinc();
        return;
      end
    end
    c = blank();
    c.rf_we = !rd0; c.chk_wb = 1'b1; c.wb_sel = (cls == C_LD) ? 2'd2 : 2'd1;
    exp_q.push_back(c);
    push_pcinc();
  endtask

  task automatic check_cycle(input cyc_t c);
    chk("imem_req", bus_if.imem_req, c.imem_req);
    chk("dmem_req", bus_if.dmem_req, c.dmem_req);
    if (c.dmem_req) chk("dmem_we", bus_if.dmem_we, c.dmem_we);
    chk("ir_we", ir_we, c.ir_we);
    chk("alu_out_we", alu_out_we, c.alu_out_we);
    chk("rf_we", rf_we, c.rf_we);
    chk("pc_we", pc_we, c.pc_we);
    chk("illegal_instr", illegal, c.illegal);
    chk("bus_error", bus_err, c.bus_err);
    chk("instret", instret, 32'(exp_ret % (1 << CW)));
    if (c.chk_alu) begin
      chk("alu_a_sel", a_sel, c.a_sel);
      chk("alu_b_sel", b_sel, c.b_sel);
    end
    if (c.chk_wb) chk("wb_sel", wb_sel, c.wb_sel);
    if (c.chk_pc) chk("pc_src", pc_src, c.pc_src);
  endtask

  // Entered at a negedge; drives each cycle, checks 1ns later, moves to the next negedge.
  task automatic run_queue(input int max_cycles);
    cyc_t c;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      c = exp_q.pop_front();
      ir = c.ir;
      bus_if.imem_ready = c.imem_ready;
      bus_if.dmem_ready = c.dmem_ready;
      #1;
      check_cycle(c);
      if (c.pc_we) exp_ret++;
      n++;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic run_instr(input logic [31:0] w, input int di, input int dd);
    model_instr(w, di, dd);
    run_queue(1000);
  endtask

  task automatic check_reset_outputs();
    chk("rst imem_req", bus_if.imem_req, 1'b0);
    chk("rst dmem_req", bus_if.dmem_req, 1'b0);
    chk("rst dmem_we", bus_if.dmem_we, 1'b0);
    chk("rst ir_we", ir_we, 1'b0);
    chk("rst alu_out_we", alu_out_we, 1'b0);
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst pc_we", pc_we, 1'b0);
    chk("rst illegal", illegal, 1'b0);
    chk("rst bus_error", bus_err, 1'b0);
    chk("rst sels", {a_sel, b_sel, wb_sel, pc_src}, 8'h00);
    chk("rst instret", instret, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [9];
    int          pick;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
             7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
    w    = $urandom;
    pick = int'($urandom_range(0, 9));
    if (pick < 9) w[6:0] = opcs[pick];
    if ($urandom_range(0, 3) != 0) begin
      w[14:12] = (w[6:0] == 7'b0000011 || w[6:0] == 7'b0100011) ? 3'b010 : 3'b000;
      if (w[6:0] == 7'b0110011) w[31:25] = 7'b0;
    end
    if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    ir = 32'h0;
    bus_if.imem_ready = 1'b0;
    bus_if.dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    run_instr(32'h00500093, 0, 0);   // ADDI x1,x0,5
    run_instr(32'h0040A103, 0, 3);   // LW x2,4(x1), data ready after 3 waits
    run_instr(32'h0020A023, 1, 0);   // SW x2,0(x1)
    run_instr(32'h008080E7, 0, 0);   // JALR x1,8(x1)
    run_instr(32'h403100B3, 0, 0);   // SUB is unsupported
    run_instr(32'h0000006F, 2, 0);   // JAL x0: no link write
    run_instr(32'h002081B3, 0, 0);   // ADD x3,x1,x2
    run_instr(32'h123452B7, 0, 0);   // LUI x5
    run_instr(32'h00000297, 0, 0);   // AUIPC x5
    run_instr(32'h00000013, 0, 0);   // ADDI x0: no rf write
    run_instr(32'h00500093, 6, 0);   // fetch timeout
    run_instr(32'h00500093, LIMIT, 0);    // fetch ready on the limit cycle
    run_instr(32'h0040A103, 0, LIMIT);    // load ready on the limit cycle
    run_instr(32'h0040A103, 0, LIMIT + 3); // load timeout
    run_instr(32'h0020A023, 0, LIMIT + 1); // store timeout

    for (int i = 0; i < 80; i++) begin
      junk = 1'($urandom_range(0, 1));
      run_instr(rand_instr(), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    end
    junk = 1'b0;

    // Reset while a load waits on data.
    model_instr(32'h0040A103, 0, 10);
    run_queue(6);
    rst = 1'b1;
    bus_if.imem_ready = 1'b0;
    bus_if.dmem_ready = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    run_instr(32'h00500093, 1, 0);
    run_instr(32'h0040A103, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
